mdu_sched: RTL

Issue/sequencing controller for the multiply-divide unit in the P6 pipeline E stage. Accepts MDU-class operations from E, owns the architectural HI/LO registers, and models the multi-cycle latency of multiply and divide with a countdown. Raises a stall request to the hazard unit while a later MDU-class instruction must wait. Serves MFHI/MFLO read data back to the E-stage result mux.

---
 rtl/mdu_sched.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mdu_sched.sv
// -----------------------------------------------------------------------------
// mdu_sched
// Issue/sequencing controller for the multiply-divide unit in the E stage.
// Owns the architectural HI/LO registers. Multi-cycle latency of multiply and
// divide is modelled with a countdown. The result is computed at issue, held in
// pending registers and committed to HI/LO when the countdown expires.
//
// Parameters
//   MUL_LAT  busy cycles for MULT/MULTU/MADD/MADDU (1..15)
//   DIV_LAT  busy cycles for DIV/DIVU (1..15)
//
// Optional feature macro
//   MDU_SCHED_MADD_EN  when defined, op codes 9/10 are MADD/MADDU
//                      (accumulate into {HI,LO}). When undefined, they decode
//                      as NOP and the accumulate adder is not built.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_op_valid   E-stage instruction is live
//   i_op[3:0]    0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO,
//                7 MTHI, 8 MTLO, 9 MADD, 10 MADDU; other codes are NOP
//   i_a, i_b     rs / rt operands (forwarded)
//   i_flush      abort in-flight op; overrides i_op_valid
//   o_busy       multi-cycle op in flight
//   o_stall      combinational stall request to the hazard unit
//   o_rd_data    HI for an accepted MFHI, LO for an accepted MFLO, else 0
//   o_hi, o_lo   architectural HI / LO
// -----------------------------------------------------------------------------
module mdu_sched #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_op_valid,
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_stall,
    output logic [31:0] o_rd_data,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [3:0] L_MUL = 4'(MUL_LAT);
    localparam logic [3:0] L_DIV = 4'(DIV_LAT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_we;     // cleared for divide-by-zero: HI/LO stay put

    // ---------------- decode ----------------
    logic w_is_mul;
    logic w_is_div;
    logic w_is_madd;
    logic w_madd_signed;
    logic w_is_base;
    logic w_is_mdu;
    logic w_req;
    logic w_accept;

    assign w_is_mul  = (i_op == OP_MULT) || (i_op == OP_MULTU);
    assign w_is_div  = (i_op == OP_DIV)  || (i_op == OP_DIVU);
    assign w_is_base = (i_op >= OP_MULT) && (i_op <= OP_MTLO);

`ifdef MDU_SCHED_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    assign w_is_madd     = (i_op == OP_MADD) || (i_op == OP_MADDU);
    assign w_madd_signed = (i_op == OP_MADD);
`else
    assign w_is_madd     = 1'b0;
    assign w_madd_signed = 1'b0;
`endif

    assign w_is_mdu = w_is_base || w_is_madd;
    assign w_req    = i_op_valid && !i_flush && w_is_mdu;
    assign w_accept = w_req && (r_state == ST_IDLE);

    assign o_busy  = (r_state != ST_IDLE);
    assign o_stall = w_req && o_busy;

    always_comb begin
        o_rd_data = 32'd0;
        if (w_accept && (i_op == OP_MFHI)) begin
            o_rd_data = r_hi;
        end else if (w_accept && (i_op == OP_MFLO)) begin
            o_rd_data = r_lo;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

    // ---------------- multiply ----------------
    // Sign- or zero-extend to 64 bits; the low 64 bits of the 64x64 product
    // are the exact signed or unsigned 32x32 product.
    logic        w_mul_signed;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;

    assign w_mul_signed = (i_op == OP_MULT) || w_madd_signed;
    assign w_mul_a = {{32{w_mul_signed & i_a[31]}}, i_a};
    assign w_mul_b = {{32{w_mul_signed & i_b[31]}}, i_b};
    assign w_prod  = w_mul_a * w_mul_b;

`ifdef MDU_SCHED_MADD_EN
    logic [63:0] w_acc;
    // HI/LO cannot change while busy, so the issue-time value is the one
    // that would be seen at commit.
    assign w_acc = {r_hi, r_lo} + w_prod;
`endif

    // ---------------- divide ----------------
    // Divide magnitudes and re-apply signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 falls out naturally
    // as quotient 0x80000000, remainder 0.
    logic        w_div_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_div_zero;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_div_signed = (i_op == OP_DIV);
    assign w_a_neg      = w_div_signed & i_a[31];
    assign w_b_neg      = w_div_signed & i_b[31];
    assign w_a_mag      = w_a_neg ? (32'd0 - i_a) : i_a;
    assign w_b_mag      = w_b_neg ? (32'd0 - i_b) : i_b;
    assign w_div_zero   = (i_b == 32'd0);
    assign w_q_mag      = w_div_zero ? 32'd0 : (w_a_mag / w_b_mag);
    assign w_r_mag      = w_div_zero ? 32'd0 : (w_a_mag % w_b_mag);
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem        = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (w_is_mul || w_is_madd)) begin
                    w_state_next = ST_MUL;
                end else if (w_accept && w_is_div) begin
                    w_state_next = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                if (i_flush || (r_cnt == 4'd1)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_we <= 1'b0;
        end else if (w_accept) begin
            if (w_is_mul) begin
                r_pend_hi <= w_prod[63:32];
                r_pend_lo <= w_prod[31:0];
                r_pend_we <= 1'b1;
                r_cnt     <= L_MUL;
`ifdef MDU_SCHED_MADD_EN
            end else if (w_is_madd) begin
                r_pend_hi <= w_acc[63:32];
                r_pend_lo <= w_acc[31:0];
                r_pend_we <= 1'b1;
                r_cnt     <= L_MUL;
`endif
            end else if (w_is_div) begin
                r_pend_hi <= w_rem;
                r_pend_lo <= w_quot;
                r_pend_we <= !w_div_zero;
                r_cnt     <= L_DIV;
            end else if (i_op == OP_MTHI) begin
                r_hi <= i_a;
            end else if (i_op == OP_MTLO) begin
                r_lo <= i_a;
            end
        end else if (r_state != ST_IDLE) begin
            if (i_flush) begin
                r_cnt     <= 4'd0;
                r_pend_hi <= 32'd0;
                r_pend_lo <= 32'd0;
                r_pend_we <= 1'b0;
            end else if (r_cnt == 4'd1) begin
                if (r_pend_we) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
                r_cnt     <= 4'd0;
                r_pend_we <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

endmodule
